// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start(1), WIDTH data bits LSB-first, parity, stop(0).
// Reassembles the word, flags parity/framing errors and counts errored frames.
module serial_frame_rx #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             si,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             perr,
    output logic             ferr,
    output logic             busy,
    output logic [7:0]       errcnt
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sh;
    logic             pe;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= IDLE;
            cnt    <= '0;
            sh     <= '0;
            pe     <= 1'b0;
            q      <= '0;
            valid  <= 1'b0;
            perr   <= 1'b0;
            ferr   <= 1'b0;
            busy   <= 1'b0;
            errcnt <= '0;
        end else begin
            valid <= 1'b0;
            if (en) begin
                case (state)
                    IDLE: begin
                        if (si) begin
                            state <= DATA;
                            cnt   <= '0;
                            sh    <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    DATA: begin
                        sh <= {si, sh[WIDTH-1:1]};
                        // Hold the counter on the last bit so it never wraps.
                        if (cnt == CW'(WIDTH - 1)) begin
                            state <= PARITY;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    PARITY: begin
                        pe    <= (^sh) ^ si ^ PARITY_ODD;
                        state <= STOP;
                    end
                    STOP: begin
                        q     <= sh;
                        perr  <= pe;
                        ferr  <= si;
                        valid <= 1'b1;
                        busy  <= 1'b0;
                        if ((pe || si) && (errcnt != 8'hFF)) begin
                            errcnt <= errcnt + 8'd1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: even- and odd-parity instances share one serial
// stream and are checked against a frame-level reference model.
module tb_serial_frame_rx;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         clr;
    logic         si;
    logic         en;
    logic [W-1:0] q0, q1;
    logic         v0, v1, pe0, pe1, fe0, fe1, b0, b1;
    logic [7:0]   ec0, ec1;

    always #5 clk = ~clk;

    serial_frame_rx #(.WIDTH(W), .PARITY_ODD(1'b0)) dut_even (
        .clk(clk), .clr(clr), .si(si), .en(en),
        .q(q0), .valid(v0), .perr(pe0), .ferr(fe0), .busy(b0), .errcnt(ec0)
    );

    serial_frame_rx #(.WIDTH(W), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .clr(clr), .si(si), .en(en),
        .q(q1), .valid(v1), .perr(pe1), .ferr(fe1), .busy(b1), .errcnt(ec1)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: last completed frame per instance plus saturating error count.
    logic [W-1:0] mq0, mq1;
    logic         mpe0, mpe1, mfe0, mfe1;
    int           mec0, mec1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        mq0 = '0; mq1 = '0;
        mpe0 = 1'b0; mpe1 = 1'b0; mfe0 = 1'b0; mfe1 = 1'b0;
        mec0 = 0; mec1 = 0;
    endtask

    // Packed view {valid, busy, perr, ferr, errcnt, q} of each instance.
    task automatic snap(input string tag, input logic ev, input logic eb);
        chk({tag, "_even"}, {v0, b0, pe0, fe0, ec0, q0}, {ev, eb, mpe0, mfe0, 8'(mec0), mq0});
        chk({tag, "_odd"},  {v1, b1, pe1, fe1, ec1, q1}, {ev, eb, mpe1, mfe1, 8'(mec1), mq1});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bit strobe, preceded by `gap` cycles of en=0 carrying junk on si.
    task automatic strobe(input logic b, input int gap, input logic in_frame);
        for (int i = 0; i < gap; i++) begin
            en = 1'b0;
            si = 1'($urandom);
            tick();
            snap("gap", 1'b0, in_frame);
        end
        en = 1'b1;
        si = b;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            en = 1'($urandom);
            si = 1'b0;
            tick();
            snap("idle", 1'b0, 1'b0);
        end
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic pbit, input logic sbit, input int gap);
        strobe(1'b1, gap, 1'b0);
        snap("start", 1'b0, 1'b1);
        for (int i = 0; i < int'(W); i++) begin
            strobe(d[i], gap, 1'b1);
            snap("data", 1'b0, 1'b1);
        end
        strobe(pbit, gap, 1'b1);
        snap("parity", 1'b0, 1'b1);
        strobe(sbit, gap, 1'b1);
        mq0  = d;
        mq1  = d;
        mpe0 = (^d) ^ pbit;
        mpe1 = (^d) ^ pbit ^ 1'b1;
        mfe0 = sbit;
        mfe1 = sbit;
        if ((mpe0 || sbit) && mec0 < 255) mec0++;
        if ((mpe1 || sbit) && mec1 < 255) mec1++;
        snap("stop", 1'b1, 1'b0);
    endtask

    initial begin
        logic [W-1:0] d;

        // Reset held while the line toggles.
        reset_model();
        clr = 1'b1;
        en  = 1'b1;
        si  = 1'b1;
        tick();
        si = 1'b0;
        tick();
        snap("reset", 1'b0, 1'b0);
        clr = 1'b0;
        idle(3);

        // Clean A5, even parity bit 0.
        send_frame(8'hA5, 1'b0, 1'b0, 0);
        chk("clean_q", 32'(q0), 32'hA5);
        idle(2);

        // Parity bit 1: even instance errors, odd instance accepts.
        send_frame(8'hA5, 1'b1, 1'b0, 0);
        chk("parerr_even", 32'(pe0), 32'd1);
        chk("parerr_odd", 32'(pe1), 32'd0);

        // Framing error; the stop-bit 1 must not open a new frame.
        d = W'($urandom);
        send_frame(d, ^d, 1'b1, 0);
        en = 1'b1; si = 1'b0;
        tick();
        snap("after_ferr", 1'b0, 1'b0);
        idle(2);

        // en toggling 1,0,1,0 during 3C.
        send_frame(8'h3C, 1'b0, 1'b0, 1);
        chk("gated_q", 32'(q0), 32'h3C);
        idle(1);

        // Reset mid-frame discards the partial word.
        strobe(1'b1, 0, 1'b0);
        strobe(1'b1, 0, 1'b1);
        strobe(1'b0, 0, 1'b1);
        snap("partial", 1'b0, 1'b1);
        #2;
        clr = 1'b1;
        reset_model();
        #1;
        snap("async_clr", 1'b0, 1'b0);
        tick();
        tick();
        snap("clr_held", 1'b0, 1'b0);
        clr = 1'b0;
        idle(2);
        send_frame(8'h5A, 1'b0, 1'b0, 0);

        // Random frames with random gaps and idle spacing.
        for (int n = 0; n < 24; n++) begin
            d = W'($urandom);
            send_frame(d, 1'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
            idle($urandom_range(0, 2));
        end

        // 260 back-to-back frames, each a parity error on the even instance.
        for (int n = 0; n < 260; n++) begin
            d = W'($urandom);
            send_frame(d, ~(^d), 1'b0, 0);
        end
        chk("errcnt_sat", 32'(ec0), 32'd255);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
